// File: rtl/overlay_bounce_ctrl.sv
// overlay_bounce_ctrl
//   Moves the text overlay's origin around the screen in 8-pixel cell units.
//   The origin bounces off the screen edges, and the colour index advances on
//   each bounce. Moves are paced by vsync, with free-run at four speeds,
//   pause, and single-step.
// Ports:
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   ena             block enable (the vsync sampler always runs)
//   vsync           active-high vsync, synchronous to clk
//   run, step       free-run select / single-move request while paused
//   speed           move period = 4 - speed frames
//   org_x, org_y    overlay origin in cells
//   dir_x, dir_y    current direction (1 = right/down)
//   color           colour index, +1 per axis bounce, wraps modulo 8
//   bounce, corner  one-cycle pulses: any axis hit / both axes hit
//   running         FSM is in RUN
module overlay_bounce_ctrl #(
  parameter int GLYPH_W = 22,
  parameter int GLYPH_H = 9,
  parameter int SCR_W   = 80,
  parameter int SCR_H   = 60,
  parameter int INIT_X  = 30,
  parameter int INIT_Y  = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       vsync,
  input  logic       run,
  input  logic       step,
  input  logic [1:0] speed,
  output logic [6:0] org_x,
  output logic [5:0] org_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic [2:0] color,
  output logic       bounce,
  output logic       corner,
  output logic       running
);

  localparam logic [6:0] XMAX = 7'(SCR_W - GLYPH_W);
  localparam logic [5:0] YMAX = 6'(SCR_H - GLYPH_H);

  typedef enum logic {PAUSE, RUN} state_t;

  state_t     state_q;
  logic [1:0] frm_cnt_q;
  logic       step_pend_q;
  logic       vs_d_q;
  logic [6:0] org_x_q;
  logic [5:0] org_y_q;
  logic       dir_x_q, dir_y_q;
  logic [2:0] color_q;
  logic       bounce_q, corner_q;

  logic       tick;
  logic       step_req;
  logic       do_move;
  logic [1:0] frm_lim;
  logic [6:0] org_x_d;
  logic [5:0] org_y_d;
  logic       dir_x_d, dir_y_d;
  logic       bnc_x, bnc_y;

  // Rising edge of vsync, gated by enable; a long vsync gives one tick.
  assign tick     = vsync & ~vs_d_q & ena;
  // A step arriving on the tick cycle itself still counts for that tick.
  assign step_req = step_pend_q | step;
  assign frm_lim  = 2'd3 - speed;

  // Move decision for the current tick.
  always_comb begin
    do_move = 1'b0;
    if (tick) begin
      if (state_q == PAUSE) begin
        do_move = ~run & step_req;
      end else begin
        do_move = run & (frm_cnt_q >= frm_lim);
      end
    end
  end

  // Next X position; a hit on an edge reflects to one cell inside.
  always_comb begin
    org_x_d = org_x_q;
    dir_x_d = dir_x_q;
    bnc_x   = 1'b0;
    if (dir_x_q) begin
      if (org_x_q == XMAX) begin
        org_x_d = XMAX - 7'd1;
        dir_x_d = 1'b0;
        bnc_x   = 1'b1;
      end else begin
        org_x_d = org_x_q + 7'd1;
      end
    end else begin
      if (org_x_q == 7'd0) begin
        org_x_d = 7'd1;
        dir_x_d = 1'b1;
        bnc_x   = 1'b1;
      end else begin
        org_x_d = org_x_q - 7'd1;
      end
    end
  end

  // Next Y position, same rule as X.
  always_comb begin
    org_y_d = org_y_q;
    dir_y_d = dir_y_q;
    bnc_y   = 1'b0;
    if (dir_y_q) begin
      if (org_y_q == YMAX) begin
        org_y_d = YMAX - 6'd1;
        dir_y_d = 1'b0;
        bnc_y   = 1'b1;
      end else begin
        org_y_d = org_y_q + 6'd1;
      end
    end else begin
      if (org_y_q == 6'd0) begin
        org_y_d = 6'd1;
        dir_y_d = 1'b1;
        bnc_y   = 1'b1;
      end else begin
        org_y_d = org_y_q - 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PAUSE;
      frm_cnt_q   <= 2'd0;
      step_pend_q <= 1'b0;
      vs_d_q      <= 1'b0;
      org_x_q     <= 7'(INIT_X);
      org_y_q     <= 6'(INIT_Y);
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      color_q     <= 3'd0;
      bounce_q    <= 1'b0;
      corner_q    <= 1'b0;
    end else begin
      vs_d_q   <= vsync;
      // Pulses are cleared every cycle, even while disabled.
      bounce_q <= do_move & (bnc_x | bnc_y);
      corner_q <= do_move & bnc_x & bnc_y;

      if (ena) begin
        // Pending step: dropped in RUN, consumed by a paused move.
        if (state_q == RUN) begin
          step_pend_q <= 1'b0;
        end else if (do_move) begin
          step_pend_q <= 1'b0;
        end else if (step) begin
          step_pend_q <= 1'b1;
        end
      end

      if (tick) begin
        case (state_q)
          PAUSE: begin
            if (run) begin
              state_q   <= RUN;
              frm_cnt_q <= 2'd0;
            end
          end
          RUN: begin
            if (!run) begin
              state_q   <= PAUSE;
              frm_cnt_q <= 2'd0;
            end else if (frm_cnt_q >= frm_lim) begin
              frm_cnt_q <= 2'd0;
            end else begin
              frm_cnt_q <= frm_cnt_q + 2'd1;
            end
          end
          default: state_q <= PAUSE;
        endcase
      end

      if (do_move) begin
        org_x_q <= org_x_d;
        org_y_q <= org_y_d;
        dir_x_q <= dir_x_d;
        dir_y_q <= dir_y_d;
        color_q <= color_q + {2'b00, bnc_x} + {2'b00, bnc_y};
      end
    end
  end

  assign org_x   = org_x_q;
  assign org_y   = org_y_q;
  assign dir_x   = dir_x_q;
  assign dir_y   = dir_y_q;
  assign color   = color_q;
  assign bounce  = bounce_q;
  assign corner  = corner_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_overlay_bounce_ctrl.sv
module tb_overlay_bounce_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst2_n = 1'b0;
  logic       ena = 1'b1;
  logic       vsync = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [1:0] speed = 2'd3;

  logic [6:0] org_x, org_x2;
  logic [5:0] org_y, org_y2;
  logic       dir_x, dir_y, dir_x2, dir_y2;
  logic [2:0] color, color2;
  logic       bounce, corner, running;
  logic       bounce2, corner2, running2;

  // Outputs captured just after the edge where a vsync pulse ticks.
  logic       b1, c1, b2, c2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  overlay_bounce_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .vsync(vsync), .run(run),
    .step(step), .speed(speed), .org_x(org_x), .org_y(org_y),
    .dir_x(dir_x), .dir_y(dir_y), .color(color), .bounce(bounce),
    .corner(corner), .running(running)
  );

  overlay_bounce_ctrl #(.INIT_X(57), .INIT_Y(50)) u_cor (
    .clk(clk), .rst_n(rst2_n), .ena(ena), .vsync(vsync), .run(run),
    .step(step), .speed(speed), .org_x(org_x2), .org_y(org_y2),
    .dir_x(dir_x2), .dir_y(dir_y2), .color(color2), .bounce(bounce2),
    .corner(corner2), .running(running2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    @(posedge clk);
    #1 vsync = 1'b1;
    @(posedge clk);
    #1;
    b1 = bounce; c1 = corner; b2 = bounce2; c2 = corner2;
    vsync = 1'b0;
    cyc(2);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vsync = ~vsync;
      cyc(1);
    end
    vsync = 1'b0;
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic step_pulse();
    @(posedge clk);
    #1 step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
  endtask

  initial begin
    // Reset with vsync toggling
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      vsync = ~vsync;
      cyc(1);
    end
    chk("rst_org_x", 32'(org_x), 32'd30);
    chk("rst_org_y", 32'(org_y), 32'd25);
    chk("rst_dir", {30'd0, dir_x, dir_y}, 32'd3);
    chk("rst_color", 32'(color), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_bounce", 32'(bounce), 32'd0);
    vsync = 1'b0;
    rst_n = 1'b1;
    cyc(2);

    // Fast free-run: entry tick then four moves
    run = 1'b1; speed = 2'd3;
    for (int i = 0; i < 5; i++) pulse();
    chk("fast_org_x", 32'(org_x), 32'd34);
    chk("fast_org_y", 32'(org_y), 32'd29);
    chk("fast_running", 32'(running), 32'd1);

    // Slowest speed: moves on pulses 5 and 9 only
    do_reset();
    run = 1'b1; speed = 2'd0;
    for (int i = 1; i <= 9; i++) begin
      pulse();
      if (i == 4) chk("slow_p4_org_x", 32'(org_x), 32'd30);
      if (i == 5) chk("slow_p5_org_x", 32'(org_x), 32'd31);
      if (i == 8) chk("slow_p8_org_x", 32'(org_x), 32'd31);
    end
    chk("slow_org_x", 32'(org_x), 32'd32);
    chk("slow_org_y", 32'(org_y), 32'd27);

    // Continuous run into the bottom and right edges
    do_reset();
    run = 1'b1; speed = 2'd3;
    pulse();
    for (int m = 1; m <= 29; m++) begin
      pulse();
      if (m == 26) begin
        chk("m26_org_y", 32'(org_y), 32'd51);
        chk("m26_bounce", 32'(b1), 32'd0);
      end
      if (m == 27) begin
        chk("m27_org_y", 32'(org_y), 32'd50);
        chk("m27_dir_y", 32'(dir_y), 32'd0);
        chk("m27_bounce", 32'(b1), 32'd1);
        chk("m27_corner", 32'(c1), 32'd0);
        chk("m27_color", 32'(color), 32'd1);
      end
      if (m == 29) begin
        chk("m29_org_x", 32'(org_x), 32'd57);
        chk("m29_dir_x", 32'(dir_x), 32'd0);
        chk("m29_bounce", 32'(b1), 32'd1);
        chk("m29_color", 32'(color), 32'd2);
      end
    end
    chk("bounce_cleared", 32'(bounce), 32'd0);

    // Corner hit from (57,50)
    @(posedge clk);
    #1 rst2_n = 1'b1;
    pulse();
    pulse();
    chk("cor_m1_org", {25'd0, org_x2}, 32'd58);
    chk("cor_m1_org_y", 32'(org_y2), 32'd51);
    pulse();
    chk("cor_m2_org_x", 32'(org_x2), 32'd57);
    chk("cor_m2_org_y", 32'(org_y2), 32'd50);
    chk("cor_m2_dir", {30'd0, dir_x2, dir_y2}, 32'd0);
    chk("cor_m2_bounce", 32'(b2), 32'd1);
    chk("cor_m2_corner", 32'(c2), 32'd1);
    chk("cor_m2_color", 32'(color2), 32'd2);
    chk("cor_corner_cleared", 32'(corner2), 32'd0);

    // Pause and single-step
    run = 1'b0;
    do_reset();
    step_pulse();
    cyc(2);
    chk("step_before_tick", 32'(org_x), 32'd30);
    @(posedge clk);
    #1 vsync = 1'b1;
    cyc(100);
    vsync = 1'b0;
    chk("step_org_x", 32'(org_x), 32'd31);
    chk("step_org_y", 32'(org_y), 32'd26);
    for (int i = 0; i < 3; i++) pulse();
    chk("step_once_x", 32'(org_x), 32'd31);
    chk("step_once_y", 32'(org_y), 32'd26);
    chk("step_running", 32'(running), 32'd0);

    // Disabled: step ignored, vsync ignored
    ena = 1'b0;
    step_pulse();
    pulse();
    pulse();
    chk("ena0_org_x", 32'(org_x), 32'd31);
    chk("ena0_org_y", 32'(org_y), 32'd26);
    ena = 1'b1;
    cyc(1);
    pulse();
    chk("ena0_step_dropped", 32'(org_x), 32'd31);

    // Asynchronous reset mid-frame
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_org_x", 32'(org_x), 32'd30);
    chk("async_org_y", 32'(org_y), 32'd25);
    rst_n = 1'b1;
    cyc(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/overlay_bounce_ctrl.md
Name: overlay_bounce_ctrl

Overview:
- Frame-synchronous sequencer that moves the text overlay's origin around the 640x480 screen in 8-pixel cell units. It bounces the origin off the screen edges, "DVD-logo" style.
- Sits between the VGA timing generator (vsync) and the overlay renderer. Supplies the cell origin that the renderer subtracts from x[9:3] and y[8:3], plus a colour index that advances on each bounce.
- Supports free-run at four speeds, pause, and single-step.

Parameters:
- GLYPH_W, 22, overlay width in cells
- GLYPH_H, 9, overlay height in cells
- SCR_W, 80, screen width in cells
- SCR_H, 60, screen height in cells
- INIT_X, 30, reset origin X (cells)
- INIT_Y, 25, reset origin Y (cells)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; 0 freezes all state except the vsync sampler
- vsync  in  1  active-high vsync, synchronous to clk
- run  in  1  1 = free-run, 0 = paused
- step  in  1  single-cycle pulse; requests one move while paused
- speed  in  2  move period = 4 - speed frames (0 gives 4 frames, 3 gives every frame)
- org_x  out  7  overlay origin X, range 0..XMAX, where XMAX = SCR_W - GLYPH_W (58)
- org_y  out  6  overlay origin Y, range 0..YMAX, where YMAX = SCR_H - GLYPH_H (51)
- dir_x  out  1  1 = moving right, 0 = moving left
- dir_y  out  1  1 = moving down, 0 = moving up
- color  out  3  colour index; wraps modulo 8
- bounce  out  1  one-cycle pulse on any edge hit
- corner  out  1  one-cycle pulse when both axes hit an edge on the same move
- running  out  1  1 when the FSM is in RUN

Behaviour:
- Reset is asynchronous and active-low. Reset values:
  - org_x = INIT_X, org_y = INIT_Y
  - dir_x = 1, dir_y = 1
  - color = 0, bounce = 0, corner = 0
  - FSM state PAUSE (running = 0), frm_cnt = 0, step_pend = 0, vs_d = 0
- Vsync sampling:
  - vs_d registers vsync every clk edge, regardless of ena.
  - tick = vsync & ~vs_d & ena.
  - vsync held high for many cycles produces exactly one tick.
- Step latch:
  - A step pulse sets step_pend. This is held until consumed or until the FSM is in RUN.
  - step arriving in the same cycle as a tick counts as pending for that tick.
- FSM, evaluated only on tick:
  - PAUSE, run = 1: go to RUN, frm_cnt = 0, no move this tick.
  - PAUSE, run = 0, step_pend or step set: one move, clear step_pend.
  - RUN, run = 0: go to PAUSE, frm_cnt = 0, no move.
  - RUN, frm_cnt >= 3 - speed: one move, frm_cnt = 0. Otherwise frm_cnt + 1.
  - The >= compare makes a speed change mid-count safe: at most one extra wait.
- Move, per axis, shown for X (Y is identical with YMAX):
  - dir_x = 1 and org_x < XMAX: org_x + 1.
  - dir_x = 1 and org_x = XMAX: org_x = XMAX - 1, dir_x = 0, axis bounce.
  - dir_x = 0 and org_x > 0: org_x - 1.
  - dir_x = 0 and org_x = 0: org_x = 1, dir_x = 1, axis bounce.
- Bounce outputs:
  - color increments by the number of axes that bounced (0, 1 or 2), modulo 8.
  - bounce = 1 if any axis bounced.
  - corner = 1 if both axes bounced.
  - Both are single-cycle pulses, cleared on the next clk edge.
- Timing: all outputs are registered and update on the clk edge at which tick = 1. Latency is one cycle after the vsync rising edge is sampled.
- ena = 0: the FSM, origin, counters and step_pend hold. step pulses are ignored. bounce and corner still clear.
- Asynchronous reset mid-move restores the reset values immediately. The first tick after release sees vs_d = 0, so vsync already high at release yields one tick.

Test Plan:
- Reset with vsync toggling: org = (30,25), dir = (1,1), color = 0, running = 0, no bounce pulse.
- run = 1, speed = 3, 5 vsync pulses: the first enters RUN, then origin reaches (34,29); running = 1.
- run = 1, speed = 0, 9 vsync pulses: the first enters RUN; moves occur on pulses 5 and 9 only, ending at (32,27).
- run = 1, speed = 3, continuous vsync:
  - At move 26, org_y = 51.
  - At move 27, org_y = 50, dir_y = 0, bounce pulse, color = 1.
  - At move 29, org_x = 57, dir_x = 0, bounce pulse, color = 2.
- INIT_X = 57, INIT_Y = 50, run = 1, speed = 3:
  - Move 1 reaches (58,51).
  - Move 2 reaches (57,50), with dir = (0,0), bounce = 1, corner = 1, color = 2.
- Pause and step, with run = 0:
  - A step pulse, then vsync held high for 100 cycles, then 3 more pulses: exactly one move, to (31,26).
  - Next, ena = 0 with a step pulse and 2 vsync pulses: no change.
  - Then rst_n asserted mid-frame: async return to (30,25).
